// File: rtl/vx_mem_responder_pkg.sv
// Shared types and sizing for the vx_mem_responder memory-bus slave.
// The optional MEM_RESPONDER_PERF_EN build uses PERF_CTR_BITS for its counters.
package vx_mem_responder_pkg;

  localparam int DATA_SIZE     = 4;
  localparam int ADDR_WIDTH    = 10;
  localparam int TAG_WIDTH     = 8;
  localparam int LATENCY       = 2;
  localparam int RSP_DEPTH     = 4;
  localparam int DATA_WIDTH    = 8 * DATA_SIZE;
  localparam int PENDING_W     = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W         = $clog2(RSP_DEPTH);
  localparam int PERF_CTR_BITS = 44;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
  } rsp_entry_t;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [DATA_SIZE-1:0]  byteen
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < DATA_SIZE; i++) begin
      if (byteen[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/vx_mem_responder_fifo.sv
// Response FIFO with a registered head: the output register is reloaded every edge
// from the entry that will be at the head after that edge's push/pop.
module vx_mem_responder_fifo
  import vx_mem_responder_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  rsp_entry_t din,
  input  logic       pop,
  output logic       valid,
  output rsp_entry_t dout,
  output logic       full,
  output logic       empty
);

  rsp_entry_t       mem_r [RSP_DEPTH];
  logic [PTR_W:0]   wr_ptr_r;
  logic [PTR_W:0]   rd_ptr_r;
  logic [PTR_W:0]   wr_next_s;
  logic [PTR_W:0]   rd_next_s;
  logic             pop_s;
  logic             valid_r;
  rsp_entry_t       dout_r;
  rsp_entry_t       dout_next_s;

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                 (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
  assign pop_s = pop & valid_r;
  assign valid = valid_r;
  assign dout  = dout_r;

  // Next pointers and next head; a push into an empty-after-pop FIFO bypasses the array.
  always_comb begin
    wr_next_s = wr_ptr_r + (PTR_W+1)'(push);
    rd_next_s = rd_ptr_r + (PTR_W+1)'(pop_s);
    if (push && (rd_next_s == wr_ptr_r)) begin
      dout_next_s = din;
    end else begin
      dout_next_s = mem_r[rd_next_s[PTR_W-1:0]];
    end
  end

  // Pointer and head-valid state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      valid_r  <= 1'b0;
    end else begin
      wr_ptr_r <= wr_next_s;
      rd_ptr_r <= rd_next_s;
      valid_r  <= (rd_next_s != wr_next_s);
    end
  end

  // Storage array and head data register carry no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r[PTR_W-1:0]] <= din;
    end
    dout_r <= dout_next_s;
  end

endmodule

// File: rtl/vx_mem_responder_fifo_chk.sv
// Simulation-only guard on the response FIFO: push into a full FIFO or pop from an empty one.
module vx_mem_responder_fifo_chk (
  input logic clk,
  input logic reset,
  input logic push,
  input logic pop,
  input logic full,
  input logic empty
);

  overflow_a: assert property (@(posedge clk) disable iff (reset) !(push && full));
  underflow_a: assert property (@(posedge clk) disable iff (reset) !(pop && empty));

endmodule

// File: rtl/vx_mem_responder.sv
// Memory-bus slave over a local SRAM: fixed-latency reads, credit-limited response FIFO.
// Define MEM_RESPONDER_PERF_EN to add perf_reads/perf_writes/perf_stalls counters.
module vx_mem_responder
  import vx_mem_responder_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_rw,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_SIZE-1:0]  req_byteen,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  input  logic                  rsp_ready
`ifdef MEM_RESPONDER_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0] perf_reads,
  output logic [PERF_CTR_BITS-1:0] perf_writes,
  output logic [PERF_CTR_BITS-1:0] perf_stalls
`endif
);

  logic [DATA_WIDTH-1:0] mem_r [2**ADDR_WIDTH];
  logic [LATENCY-1:0]    pipe_vld_r;
  rsp_entry_t            pipe_ent_r [LATENCY];
  logic [PENDING_W-1:0]  pending_r;
  logic [PENDING_W-1:0]  pending_next_s;
  logic                  req_ready_r;
  logic                  req_fire_s;
  logic                  rd_fire_s;
  logic                  wr_fire_s;
  logic                  rsp_fire_s;
  rsp_entry_t            fifo_dout_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;

  // Credits are all free while in reset; masking with reset keeps ready low during it.
  assign req_ready  = req_ready_r & ~reset;
  assign req_fire_s = req_valid & req_ready;
  assign rd_fire_s  = req_fire_s & ~req_rw;
  assign wr_fire_s  = req_fire_s & req_rw;
  assign rsp_fire_s = rsp_valid & rsp_ready;
  assign rsp_data   = fifo_dout_s.data;
  assign rsp_tag    = fifo_dout_s.tag;

  assign pending_next_s = pending_r + PENDING_W'(rd_fire_s) - PENDING_W'(rsp_fire_s);

  // Credit counter: reads in the pipeline plus FIFO occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r   <= '0;
      req_ready_r <= 1'b1;
    end else begin
      pending_r   <= pending_next_s;
      req_ready_r <= (pending_next_s < PENDING_W'(RSP_DEPTH));
    end
  end

  // SRAM byte-masked write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_r[req_addr] <= merge_bytes(mem_r[req_addr], req_data, req_byteen);
    end
  end

  // Read pipeline valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_vld_r <= '0;
    end else begin
      pipe_vld_r[0] <= rd_fire_s;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld_r[i] <= pipe_vld_r[i-1];
      end
    end
  end

  // Read pipeline payload: stage 0 captures the SRAM word and tag.
  always_ff @(posedge clk) begin
    if (rd_fire_s) begin
      pipe_ent_r[0] <= '{data: mem_r[req_addr], tag: req_tag};
    end
    for (int i = 1; i < LATENCY; i++) begin
      pipe_ent_r[i] <= pipe_ent_r[i-1];
    end
  end

  vx_mem_responder_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pipe_vld_r[LATENCY-1]),
    .din   (pipe_ent_r[LATENCY-1]),
    .pop   (rsp_fire_s),
    .valid (rsp_valid),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  vx_mem_responder_fifo_chk u_fifo_chk (
    .clk   (clk),
    .reset (reset),
    .push  (pipe_vld_r[LATENCY-1]),
    .pop   (rsp_fire_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

`ifdef MEM_RESPONDER_PERF_EN
  logic [PERF_CTR_BITS-1:0] perf_reads_r;
  logic [PERF_CTR_BITS-1:0] perf_writes_r;
  logic [PERF_CTR_BITS-1:0] perf_stalls_r;

  assign perf_reads  = perf_reads_r;
  assign perf_writes = perf_writes_r;
  assign perf_stalls = perf_stalls_r;

  // Free-running event counters; wrap on overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_reads_r  <= '0;
      perf_writes_r <= '0;
      perf_stalls_r <= '0;
    end else begin
      perf_reads_r  <= perf_reads_r + PERF_CTR_BITS'(rd_fire_s);
      perf_writes_r <= perf_writes_r + PERF_CTR_BITS'(wr_fire_s);
      perf_stalls_r <= perf_stalls_r + PERF_CTR_BITS'(req_valid & ~req_ready);
    end
  end
`endif

endmodule

// File: tb/tb_vx_mem_responder.sv
// Self-checking bench for vx_mem_responder: transaction-level reference model plus
// directed scenarios. Define MEM_RESPONDER_PERF_EN to also check the perf counters.
module tb_vx_mem_responder;
  import vx_mem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_rw = 1'b0;
  logic [9:0]  req_addr = 10'd0;
  logic [3:0]  req_byteen = 4'd0;
  logic [31:0] req_data = 32'd0;
  logic [7:0]  req_tag = 8'd0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_tag;
  logic        rsp_ready = 1'b0;
`ifdef MEM_RESPONDER_PERF_EN
  logic [43:0] perf_reads, perf_writes, perf_stalls;
`endif

  vx_mem_responder dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_rw(req_rw),
    .req_addr(req_addr), .req_byteen(req_byteen), .req_data(req_data),
    .req_tag(req_tag), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready)
`ifdef MEM_RESPONDER_PERF_EN
    , .perf_reads(perf_reads), .perf_writes(perf_writes), .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pend = 0;
  bit prev_reset = 1'b0;

  // Reference model: word memory, expected-response queue, response log.
  logic [31:0] mdl_mem [int];
  logic [31:0] exp_data [$];
  logic [7:0]  exp_tag [$];
  int          exp_t [$];
  bit          exp_known [$];
  logic [7:0]  log_tag [$];
  logic [31:0] log_data [$];
  int          log_cyc [$];
  int          rd_cyc [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model, then advance the model by this cycle's fires.
  always @(negedge clk) begin
    bit exp_v, exp_rdy;
    logic [31:0] w;
    cyc++;
    if (reset) begin
      chk("reset_req_ready", {63'd0, req_ready}, 64'd0);
      if (prev_reset) chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      exp_data.delete(); exp_tag.delete(); exp_t.delete(); exp_known.delete();
      pend = 0;
      prev_reset = 1'b1;
    end else begin
      prev_reset = 1'b0;
      exp_rdy = (pend < RSP_DEPTH);
      exp_v = (exp_t.size() > 0) && (cyc >= exp_t[0] + LATENCY + 1);
      chk("req_ready", {63'd0, req_ready}, {63'd0, exp_rdy});
      chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_v});
      if (exp_v && rsp_valid) begin
        chk("rsp_tag", {56'd0, rsp_tag}, {56'd0, exp_tag[0]});
        if (exp_known[0]) chk("rsp_data", {32'd0, rsp_data}, {32'd0, exp_data[0]});
      end
      if (exp_v && rsp_ready) begin
        log_tag.push_back(rsp_tag);
        log_data.push_back(rsp_data);
        log_cyc.push_back(cyc);
        void'(exp_data.pop_front()); void'(exp_tag.pop_front());
        void'(exp_t.pop_front()); void'(exp_known.pop_front());
        pend--;
      end
      if (req_valid && exp_rdy) begin
        if (req_rw) begin
          w = mdl_mem.exists(int'(req_addr)) ? mdl_mem[int'(req_addr)] : 32'd0;
          for (int b = 0; b < 4; b++) if (req_byteen[b]) w[8*b +: 8] = req_data[8*b +: 8];
          mdl_mem[int'(req_addr)] = w;
        end else begin
          exp_known.push_back(mdl_mem.exists(int'(req_addr)));
          exp_data.push_back(mdl_mem.exists(int'(req_addr)) ? mdl_mem[int'(req_addr)] : 32'd0);
          exp_tag.push_back(req_tag);
          exp_t.push_back(cyc);
          rd_cyc.push_back(cyc);
          pend++;
        end
      end
    end
  end

  task automatic send(input bit rw, input logic [9:0] a, input logic [3:0] be,
                      input logic [31:0] d, input logic [7:0] tg);
    bit ok = 1'b0;
    int n = 0;
    req_valid = 1'b1; req_rw = rw; req_addr = a; req_byteen = be; req_data = d; req_tag = tg;
    while (!ok && n < 64) begin
      @(negedge clk); ok = req_ready;
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL send_timeout: got no req_ready, expected acceptance of tag 0x%0h", tg);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_t.size() != 0 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    if (exp_t.size() != 0) begin
      tests++; fails++;
      $display("FAIL wait_idle: got %0d responses outstanding, expected 0", exp_t.size());
    end
  endtask

  task automatic clear_logs();
    log_tag.delete(); log_data.delete(); log_cyc.delete(); rd_cyc.delete();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    reset = 1'b0;
  endtask

  initial begin
    int acc, tg, n, st;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", {63'd0, req_ready}, 64'd1);
    chk("post_reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    @(posedge clk); #1;

    // Basic latency: response exactly LATENCY+1 cycles after the read fires.
    rsp_ready = 1'b1;
    send(1'b1, 10'h005, 4'hF, 32'hDEADBEEF, 8'h00);
    send(1'b0, 10'h005, 4'h0, 32'h0, 8'h3C);
    @(negedge clk); chk("lat_t1_valid", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk); chk("lat_t2_valid", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk); chk("lat_t3_valid", {63'd0, rsp_valid}, 64'd1);
    chk("lat_t3_data", {32'd0, rsp_data}, 64'hDEADBEEF);
    chk("lat_t3_tag", {56'd0, rsp_tag}, 64'h3C);
    @(posedge clk); #1;
    wait_idle();

    // Byte-enable merge.
    send(1'b1, 10'd7, 4'hF, 32'h11223344, 8'h00);
    send(1'b1, 10'd7, 4'b0101, 32'hAABBCCDD, 8'h00);
    clear_logs();
    send(1'b0, 10'd7, 4'h0, 32'h0, 8'h77);
    wait_idle();
    chk("byteen_count", 64'(log_data.size()), 64'd1);
    chk("byteen_data", {32'd0, log_data[0]}, 64'h11BB33DD);

    // Backpressure: only RSP_DEPTH reads accepted while responses are held.
    clear_logs();
    rsp_ready = 1'b0; acc = 0; tg = 1;
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 10'h005;
    for (int c = 0; c < 10; c++) begin
      req_tag = 8'(tg);
      @(negedge clk); if (req_ready) begin acc++; tg++; end
      @(posedge clk); #1;
    end
    chk("bp_accepted", 64'(acc), 64'd4);
    @(negedge clk); chk("bp_ready_low", {63'd0, req_ready}, 64'd0);
    chk("bp_rsp_held_tag", {56'd0, rsp_tag}, 64'd1);
    @(posedge clk); #1;
    rsp_ready = 1'b1; n = 0;
    while (tg < 7 && n < 40) begin
      req_tag = 8'(tg);
      @(negedge clk); if (req_ready) tg++;
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b0;
    wait_idle();
    chk("bp_count", 64'(log_tag.size()), 64'd6);
    for (int i = 0; i < 6 && i < log_tag.size(); i++)
      chk("bp_order", {56'd0, log_tag[i]}, 64'(i + 1));

    // Back-to-back reads: full throughput.
    clear_logs();
    for (int i = 0; i < 16; i++) send(1'b0, 10'h005, 4'h0, 32'h0, 8'(8'h40 + i));
    wait_idle();
    chk("b2b_count", 64'(log_tag.size()), 64'd16);
    if (log_cyc.size() == 16 && rd_cyc.size() == 16) begin
      chk("b2b_first", 64'(log_cyc[0]), 64'(rd_cyc[0] + 3));
      for (int i = 1; i < 16; i++) begin
        chk("b2b_consecutive", 64'(log_cyc[i]), 64'(log_cyc[0] + i));
        chk("b2b_tag", {56'd0, log_tag[i]}, 64'(8'h40 + i));
      end
    end

    // Reset with reads in flight: they vanish, memory survives.
    send(1'b1, 10'd9, 4'hF, 32'hCAFEF00D, 8'h00);
    for (int i = 0; i < 3; i++) send(1'b0, 10'd9, 4'h0, 32'h0, 8'(8'h90 + i));
    do_reset(2);
    clear_logs();
    repeat (8) begin @(posedge clk); #1; end
    chk("rst_no_rsp", 64'(log_tag.size()), 64'd0);
    send(1'b0, 10'd9, 4'h0, 32'h0, 8'hA1);
    send(1'b0, 10'h005, 4'h0, 32'h0, 8'hA2);
    wait_idle();
    chk("rst_mem_count", 64'(log_data.size()), 64'd2);
    chk("rst_mem_a", {32'd0, log_data[0]}, 64'hCAFEF00D);
    chk("rst_mem_b", {32'd0, log_data[1]}, 64'hDEADBEEF);

    // Randomized traffic against the model.
    for (int a = 0; a < 16; a++) send(1'b1, 10'(a), 4'hF, $urandom, 8'h00);
    for (int c = 0; c < 800; c++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_rw     = ($urandom_range(0, 2) == 0);
      req_addr   = 10'($urandom_range(0, 15));
      req_byteen = 4'($urandom);
      req_data   = $urandom;
      req_tag    = 8'($urandom);
      rsp_ready  = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    wait_idle();

`ifdef MEM_RESPONDER_PERF_EN
    do_reset(2);
    @(negedge clk);
    chk("perf_clr_reads", {20'd0, perf_reads}, 64'd0);
    chk("perf_clr_stalls", {20'd0, perf_stalls}, 64'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, 10'h005, 4'h0, 32'h0, 8'(i));
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 10'h005; st = 0; n = 0;
    while (st < 3 && n < 20) begin
      @(negedge clk); if (!req_ready) st++;
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    send(1'b0, 10'h005, 4'h0, 32'h0, 8'h55);
    send(1'b1, 10'd20, 4'hF, 32'h01020304, 8'h00);
    send(1'b1, 10'd21, 4'hF, 32'h05060708, 8'h00);
    wait_idle();
    chk("perf_reads", {20'd0, perf_reads}, 64'd5);
    chk("perf_writes", {20'd0, perf_writes}, 64'd2);
    chk("perf_stalls", {20'd0, perf_stalls}, 64'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: got simulation time limit, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
